// File: rtl/trdb_pkg.sv
// trdb_pkg
// Shared types for the trace debugger blocks.
//   PRIVLEN          : width of the core privilege field carried with each retired instruction
//   trdb_ctrl_kind_e : control-packet kind requested from the packet emitter
package trdb_pkg;

  localparam int PRIVLEN = 2;

  typedef enum logic [1:0] {
    START = 2'd0,
    SYNC  = 2'd1,
    EXC   = 2'd2,
    STOP  = 2'd3
  } trdb_ctrl_kind_e;

endpackage

// File: rtl/trdb_trace_ctrl.sv
// trdb_trace_ctrl
// Sequences the trace packet emitter. It follows trace enable, retired instructions,
// exceptions and privilege changes, and decides when START, SYNC, EXC and STOP
// control packets are requested. Instruction intake is stalled while a control
// packet is outstanding or the emitter is being flushed.
// Ports:
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   trace_enable_i      level, tracing requested
//   sync_period_i       retired instructions between SYNC packets (0 = periodic sync off)
//   ivalid_i            instruction retired this cycle (ignored while stall_o=1)
//   iexception_i        retired instruction traps (qualified by ivalid_i)
//   interrupt_i         the trap is an interrupt (reported as emit_irq_o)
//   priv_i              privilege of the retired instruction
//   emit_ready_i        emitter accepts the current request
//   flush_done_i        emitter/FIFO drained
//   emit_req_o          control-packet request
//   emit_kind_o         kind of the requested packet
//   emit_irq_o          interrupt flag, valid with kind EXC
//   stall_o             hold retirement stream upstream
//   flush_o             request emitter flush
//   tracing_o           trace session active
module trdb_trace_ctrl
  import trdb_pkg::*;
#(
  parameter int SYNC_CNT_W = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  trace_enable_i,
  input  logic [SYNC_CNT_W-1:0] sync_period_i,
  input  logic                  ivalid_i,
  input  logic                  iexception_i,
  input  logic                  interrupt_i,
  input  logic [PRIVLEN-1:0]    priv_i,
  input  logic                  emit_ready_i,
  input  logic                  flush_done_i,
  output logic                  emit_req_o,
  output trdb_ctrl_kind_e       emit_kind_o,
  output logic                  emit_irq_o,
  output logic                  stall_o,
  output logic                  flush_o,
  output logic                  tracing_o
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_TRACE = 3'd2;
  localparam logic [2:0] ST_EXC   = 3'd3;
  localparam logic [2:0] ST_SYNC  = 3'd4;
  localparam logic [2:0] ST_FLUSH = 3'd5;
  localparam logic [2:0] ST_STOP  = 3'd6;

  logic [2:0]            state_q, state_d;
  logic [SYNC_CNT_W-1:0] sync_cnt_q, sync_cnt_d;
  logic [PRIVLEN-1:0]    last_priv_q, last_priv_d;
  logic                  irq_q, irq_d;
  logic                  sync_due;

  // sync_period_i is used live, so a new period applies at the next compare.
  assign sync_due = (sync_period_i != '0) &&
                    (sync_cnt_q == sync_period_i - SYNC_CNT_W'(1));

  // Next-state logic. Requests are only left on emit_ready_i, so a packet is never
  // abandoned; enable changes are only looked at in IDLE and TRACE.
  always_comb begin
    state_d     = state_q;
    sync_cnt_d  = sync_cnt_q;
    last_priv_d = last_priv_q;
    irq_d       = irq_q;
    case (state_q)
      ST_IDLE: begin
        if (trace_enable_i) state_d = ST_START;
      end
      ST_START: begin
        if (emit_ready_i) begin
          state_d     = ST_TRACE;
          sync_cnt_d  = '0;
          last_priv_d = priv_i;
        end
      end
      ST_TRACE: begin
        if (!trace_enable_i) begin
          state_d = ST_FLUSH;
        end else if (ivalid_i) begin
          last_priv_d = priv_i;
          if (iexception_i) begin
            state_d    = ST_EXC;
            irq_d      = interrupt_i;
            sync_cnt_d = '0;
          end else if (priv_i != last_priv_q || sync_due) begin
            state_d    = ST_SYNC;
            sync_cnt_d = '0;
          end else if (sync_cnt_q != '1) begin
            sync_cnt_d = sync_cnt_q + SYNC_CNT_W'(1);
          end
        end
      end
      ST_EXC, ST_SYNC: begin
        if (emit_ready_i) state_d = ST_TRACE;
      end
      ST_FLUSH: begin
        if (flush_done_i) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (emit_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      sync_cnt_q  <= '0;
      last_priv_q <= '0;
      irq_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_cnt_q  <= sync_cnt_d;
      last_priv_q <= last_priv_d;
      irq_q       <= irq_d;
    end
  end

  // Moore output decode: everything follows the state register only.
  always_comb begin
    emit_req_o  = 1'b0;
    emit_kind_o = START;
    flush_o     = 1'b0;
    tracing_o   = 1'b0;
    case (state_q)
      ST_START: emit_req_o = 1'b1;
      ST_TRACE: tracing_o  = 1'b1;
      ST_EXC: begin
        emit_req_o  = 1'b1;
        emit_kind_o = EXC;
        tracing_o   = 1'b1;
      end
      ST_SYNC: begin
        emit_req_o  = 1'b1;
        emit_kind_o = SYNC;
        tracing_o   = 1'b1;
      end
      ST_FLUSH: begin
        flush_o   = 1'b1;
        tracing_o = 1'b1;
      end
      ST_STOP: begin
        emit_req_o  = 1'b1;
        emit_kind_o = STOP;
      end
      default: ;
    endcase
  end

  assign stall_o    = emit_req_o | flush_o;
  assign emit_irq_o = irq_q & (state_q == ST_EXC);

endmodule

// File: tb/tb_trdb_trace_ctrl.sv
// tb_trdb_trace_ctrl
// Scenario tasks drive trdb_trace_ctrl and compare every cycle against a
// session-level reference model (pending packet, flushing flag, instruction count).
module tb_trdb_trace_ctrl;
  import trdb_pkg::*;

  localparam int K_START = 0;
  localparam int K_SYNC  = 1;
  localparam int K_EXC   = 2;
  localparam int K_STOP  = 3;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic               trace_enable = 1'b0;
  logic [15:0]        sync_period = '0;
  logic               ivalid = 1'b0;
  logic               iexception = 1'b0;
  logic               interrupt = 1'b0;
  logic [PRIVLEN-1:0] priv = '0;
  logic               emit_ready = 1'b0;
  logic               flush_done = 1'b0;
  logic               emit_req;
  logic [1:0]         emit_kind;
  logic               emit_irq;
  logic               stall;
  logic               flush;
  logic               tracing;

  int n_cmp = 0;
  int n_fail = 0;

  // reference model state
  int                 m_pend;
  bit                 m_flushing;
  bit                 m_session;
  bit                 m_irq;
  int                 m_since;
  logic [PRIVLEN-1:0] m_last_priv;

  trdb_trace_ctrl #(.SYNC_CNT_W(16)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .trace_enable_i (trace_enable),
    .sync_period_i  (sync_period),
    .ivalid_i       (ivalid),
    .iexception_i   (iexception),
    .interrupt_i    (interrupt),
    .priv_i         (priv),
    .emit_ready_i   (emit_ready),
    .flush_done_i   (flush_done),
    .emit_req_o     (emit_req),
    .emit_kind_o    (emit_kind),
    .emit_irq_o     (emit_irq),
    .stall_o        (stall),
    .flush_o        (flush),
    .tracing_o      (tracing)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic void model_reset();
    m_pend      = -1;
    m_flushing  = 1'b0;
    m_session   = 1'b0;
    m_irq       = 1'b0;
    m_since     = 0;
    m_last_priv = '0;
  endfunction

  // One clock edge of session behaviour, using the inputs present at the edge.
  function automatic void model_edge();
    logic [PRIVLEN-1:0] prev;
    prev = m_last_priv;
    if (m_pend >= 0) begin
      if (emit_ready) begin
        if (m_pend == K_START) begin
          m_session   = 1'b1;
          m_since     = 0;
          m_last_priv = priv;
        end
        m_pend = -1;
      end
    end else if (m_flushing) begin
      if (flush_done) begin
        m_flushing = 1'b0;
        m_session  = 1'b0;
        m_pend     = K_STOP;
      end
    end else if (!m_session) begin
      if (trace_enable) m_pend = K_START;
    end else if (!trace_enable) begin
      m_flushing = 1'b1;
    end else if (ivalid) begin
      m_last_priv = priv;
      if (iexception) begin
        m_pend  = K_EXC;
        m_irq   = interrupt;
        m_since = 0;
      end else if (priv != prev) begin
        m_pend  = K_SYNC;
        m_since = 0;
      end else if (sync_period != 0 && m_since + 1 == int'(sync_period)) begin
        m_pend  = K_SYNC;
        m_since = 0;
      end else if (m_since < 65535) begin
        m_since = m_since + 1;
      end
    end
  endfunction

  // {req, kind[1:0], irq, stall, flush}
  function automatic logic [5:0] exp_vec();
    logic       req;
    logic [1:0] kind;
    req  = (m_pend >= 0);
    kind = req ? 2'(m_pend) : 2'd0;
    return {req, kind, (m_pend == K_EXC) && m_irq, req || m_flushing, m_flushing};
  endfunction

  function automatic logic [5:0] dut_vec();
    return {emit_req, emit_kind, emit_irq, stall, flush};
  endfunction

  // tracing_o is pinned down when no packet is pending and while START is pending
  function automatic bit tracing_known();
    return (m_pend < 0) || (m_pend == K_START);
  endfunction

  function automatic logic exp_tracing();
    return (m_pend < 0) && m_session;
  endfunction

  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (dut_vec() !== 6'b0) begin
      n_fail++;
      $display("[TB] FAIL reset outputs: got %b want %b", dut_vec(), 6'b0);
    end
    n_cmp++;
    if (tracing !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset tracing: got %b want 0", tracing);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_start();
    trace_enable = 1'b1;
    emit_ready   = 1'b1;
    sync_period  = '0;
    priv         = '0;
    for (int i = 0; i < 8; i++) begin
      ivalid = (i >= 2 && i < 7);
      step();
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("[TB] FAIL start i=%0d: got %b want %b", i, dut_vec(), exp_vec());
      end
      if (tracing_known()) begin
        n_cmp++;
        if (tracing !== exp_tracing()) begin
          n_fail++;
          $display("[TB] FAIL start_tracing i=%0d: got %b want %b", i, tracing, exp_tracing());
        end
      end
    end
    ivalid = 1'b0;
  endtask

  task automatic test_periodic_sync();
    int nsync;
    nsync       = 0;
    sync_period = 16'd4;
    emit_ready  = 1'b1;
    ivalid      = 1'b1;
    priv        = 2'd1;
    for (int i = 0; i < 12; i++) begin
      step();
      if (emit_req && emit_kind == 2'(K_SYNC)) nsync++;
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("[TB] FAIL periodic_sync i=%0d: got %b want %b", i, dut_vec(), exp_vec());
      end
    end
    n_cmp++;
    if (nsync !== 3) begin
      n_fail++;
      $display("[TB] FAIL periodic_sync_count: got %0d want 3", nsync);
    end
    ivalid      = 1'b0;
    sync_period = '0;
  endtask

  task automatic test_exception_stall();
    int nstall;
    nstall     = 0;
    emit_ready = 1'b1;
    ivalid     = 1'b1;
    step();
    iexception = 1'b1;
    interrupt  = 1'b1;
    emit_ready = 1'b0;
    step();
    iexception = 1'b0;
    interrupt  = 1'b0;
    n_cmp++;
    if (dut_vec() !== exp_vec() || {emit_req, emit_kind, emit_irq} !== 4'b1101) begin
      n_fail++;
      $display("[TB] FAIL exc_req: got %b want %b", dut_vec(), exp_vec());
    end
    for (int i = 0; i < 4; i++) begin
      if (stall === 1'b1) nstall++;
      emit_ready = (i == 3);
      ivalid     = 1'($urandom_range(1));
      step();
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("[TB] FAIL exc_stall i=%0d: got %b want %b", i, dut_vec(), exp_vec());
      end
    end
    n_cmp++;
    if (nstall !== 4) begin
      n_fail++;
      $display("[TB] FAIL exc_stall_cycles: got %0d want 4", nstall);
    end
    ivalid = 1'b0;
  endtask

  task automatic test_priv_exc();
    int nsync;
    nsync      = 0;
    emit_ready = 1'b1;
    ivalid     = 1'b1;
    priv       = 2'd3;
    step();
    ivalid = 1'b0;
    step();
    ivalid     = 1'b1;
    priv       = 2'd0;
    iexception = 1'b1;
    interrupt  = 1'b0;
    step();
    iexception = 1'b0;
    n_cmp++;
    if (dut_vec() !== exp_vec() || emit_kind !== 2'(K_EXC)) begin
      n_fail++;
      $display("[TB] FAIL priv_exc_req: got %b want %b", dut_vec(), exp_vec());
    end
    for (int i = 0; i < 6; i++) begin
      step();
      if (emit_req && emit_kind == 2'(K_SYNC)) nsync++;
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("[TB] FAIL priv_exc i=%0d: got %b want %b", i, dut_vec(), exp_vec());
      end
    end
    n_cmp++;
    if (nsync !== 0) begin
      n_fail++;
      $display("[TB] FAIL priv_exc_extra_sync: got %0d want 0", nsync);
    end
    ivalid = 1'b0;
  endtask

  task automatic test_flush();
    trace_enable = 1'b0;
    ivalid       = 1'b1;
    for (int i = 0; i < 14; i++) begin
      trace_enable = (i >= 3);
      flush_done   = (i == 7);
      emit_ready   = (i != 8);
      step();
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("[TB] FAIL flush i=%0d: got %b want %b", i, dut_vec(), exp_vec());
      end
      if (tracing_known()) begin
        n_cmp++;
        if (tracing !== exp_tracing()) begin
          n_fail++;
          $display("[TB] FAIL flush_tracing i=%0d: got %b want %b", i, tracing, exp_tracing());
        end
      end
    end
    flush_done = 1'b0;
    ivalid     = 1'b0;
  endtask

  task automatic test_reset_mid();
    emit_ready = 1'b0;
    ivalid     = 1'b1;
    priv       = priv + 2'd1;
    step();
    ivalid = 1'b0;
    n_cmp++;
    if (dut_vec() !== exp_vec()) begin
      n_fail++;
      $display("[TB] FAIL reset_mid_pending: got %b want %b", dut_vec(), exp_vec());
    end
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    n_cmp++;
    if ({dut_vec(), tracing} !== 7'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_mid_async: got %b want %b", {dut_vec(), tracing}, 7'b0);
    end
    step();
    rst_n        = 1'b1;
    trace_enable = 1'b1;
    emit_ready   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("[TB] FAIL reset_mid_restart i=%0d: got %b want %b", i, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      trace_enable = ($urandom_range(19) != 0);
      sync_period  = 16'($urandom_range(5));
      ivalid       = 1'($urandom_range(1));
      iexception   = ($urandom_range(9) == 0);
      interrupt    = 1'($urandom_range(1));
      if ($urandom_range(7) == 0) priv = 2'($urandom_range(3));
      emit_ready   = ($urandom_range(9) < 7);
      flush_done   = ($urandom_range(3) == 0);
      step();
      n_cmp++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++;
        $display("[TB] FAIL random i=%0d: got %b want %b", i, dut_vec(), exp_vec());
      end
      if (tracing_known()) begin
        n_cmp++;
        if (tracing !== exp_tracing()) begin
          n_fail++;
          $display("[TB] FAIL random_tracing i=%0d: got %b want %b", i, tracing, exp_tracing());
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_start();
    test_periodic_sync();
    test_exception_stall();
    test_priv_exc();
    test_flush();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
